// File: rtl/adder_tree_sequencer.sv
// Iterative pairwise reduction of NUM_INPUTS signed words, one adder layer per clock.
// Optional macro ADDER_TREE_SEQ_SATURATE_EN: saturating adds plus a sticky o_sat output.
module adder_tree_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 9
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0] i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_busy
`ifdef ADDER_TREE_SEQ_SATURATE_EN
  ,
  output logic                             o_sat
`endif
);

  localparam int PASSES = $clog2(NUM_INPUTS);
  localparam int CNT_W  = (PASSES == 0) ? 1 : $clog2(PASSES + 1);
  localparam int LIVE_W = $clog2(NUM_INPUTS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [LIVE_W-1:0]             live_q, live_d;
  logic signed [DATA_WIDTH-1:0]  bank_q [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0]  bank_d [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0]  tail;
  int                            n_live;
  int                            n_pairs;
`ifdef ADDER_TREE_SEQ_SATURATE_EN
  logic                          sat_q, sat_d;

  localparam logic signed [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Overflow only when both operands share a sign that the sum does not.
  function automatic logic add_ovf(input logic signed [DATA_WIDTH-1:0] a,
                                   input logic signed [DATA_WIDTH-1:0] b);
    logic signed [DATA_WIDTH-1:0] s;
    s = a + b;
    return (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
  endfunction
`endif

  function automatic logic signed [DATA_WIDTH-1:0] pair_add(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b);
    logic signed [DATA_WIDTH-1:0] s;
    s = a + b;
`ifdef ADDER_TREE_SEQ_SATURATE_EN
    if (add_ovf(a, b)) s = a[DATA_WIDTH-1] ? SMIN : SMAX;
`endif
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      live_q  <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) bank_q[i] <= '0;
`ifdef ADDER_TREE_SEQ_SATURATE_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= live_d;
      for (int i = 0; i < NUM_INPUTS; i++) bank_q[i] <= bank_d[i];
`ifdef ADDER_TREE_SEQ_SATURATE_EN
      sat_q   <= sat_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    live_d  = live_q;
    bank_d  = bank_q;
    tail    = '0;
    n_live  = int'(live_q);
    n_pairs = n_live / 2;
`ifdef ADDER_TREE_SEQ_SATURATE_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          for (int i = 0; i < NUM_INPUTS; i++)
            bank_d[i] = i_data[i*DATA_WIDTH +: DATA_WIDTH];
          cnt_d   = CNT_W'(PASSES);
          live_d  = LIVE_W'(NUM_INPUTS);
`ifdef ADDER_TREE_SEQ_SATURATE_EN
          sat_d   = 1'b0;
`endif
          state_d = (PASSES == 0) ? DONE : REDUCE;
        end
      end
      REDUCE: begin
        for (int j = 0; j < NUM_INPUTS; j++)
          if (j == n_live - 1) tail = bank_q[j];
        for (int k = 0; k < NUM_INPUTS; k++) bank_d[k] = '0;
        for (int k = 0; k < NUM_INPUTS / 2; k++) begin
          if (k < n_pairs) begin
            bank_d[k] = pair_add(bank_q[2*k], bank_q[2*k+1]);
`ifdef ADDER_TREE_SEQ_SATURATE_EN
            if (add_ovf(bank_q[2*k], bank_q[2*k+1])) sat_d = 1'b1;
`endif
          end
        end
        // Odd live count: the unpaired last word lands in the top live slot, index n/2.
        if ((n_live % 2) == 1) begin
          for (int k = 0; k < NUM_INPUTS; k++)
            if (k == n_pairs) bank_d[k] = tail;
        end
        live_d = LIVE_W'((n_live + 1) / 2);
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == IDLE);
    o_valid = (state_q == DONE);
    o_busy  = (state_q == REDUCE) || (state_q == DONE);
    o_data  = bank_q[0];
`ifdef ADDER_TREE_SEQ_SATURATE_EN
    o_sat   = sat_q;
`endif
  end

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Directed bench for adder_tree_sequencer: NUM_INPUTS=9 main instance plus 1- and 2-input instances.
module tb_adder_tree_sequencer;

  logic         clk;
  logic         rst_n;

  logic [287:0] d9;
  logic         v9, r9, or9, ov9, busy9;
  logic [31:0]  od9;
  logic [31:0]  d1;
  logic         v1, r1, or1, ov1, busy1;
  logic [31:0]  od1;
  logic [63:0]  d2;
  logic         v2, r2, or2, ov2, busy2;
  logic [31:0]  od2;
`ifdef ADDER_TREE_SEQ_SATURATE_EN
  logic         sat9, sat1, sat2;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int vec[9];

  adder_tree_sequencer #(.DATA_WIDTH(32), .NUM_INPUTS(9)) u9 (
    .clk(clk), .rst_n(rst_n), .i_data(d9), .i_valid(v9), .o_ready(or9),
    .o_data(od9), .o_valid(ov9), .i_ready(r9), .o_busy(busy9)
`ifdef ADDER_TREE_SEQ_SATURATE_EN
    , .o_sat(sat9)
`endif
  );

  adder_tree_sequencer #(.DATA_WIDTH(32), .NUM_INPUTS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .i_data(d1), .i_valid(v1), .o_ready(or1),
    .o_data(od1), .o_valid(ov1), .i_ready(r1), .o_busy(busy1)
`ifdef ADDER_TREE_SEQ_SATURATE_EN
    , .o_sat(sat1)
`endif
  );

  adder_tree_sequencer #(.DATA_WIDTH(32), .NUM_INPUTS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .i_data(d2), .i_valid(v2), .o_ready(or2),
    .o_data(od2), .o_valid(ov2), .i_ready(r2), .o_busy(busy2)
`ifdef ADDER_TREE_SEQ_SATURATE_EN
    , .o_sat(sat2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [287:0] pack9();
    logic [287:0] p;
    for (int i = 0; i < 9; i++) p[i*32 +: 32] = vec[i];
    return p;
  endfunction

  // Accept one vector, track latency to o_valid, check the sum; optionally check the drop after handshake.
  task automatic xfer9(input logic [287:0] d, input logic [31:0] exp, input string tag, input bit post);
    int lat;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, or9}, 32'd1);
    d9 = d;
    v9 = 1'b1;
    @(negedge clk);
    v9 = 1'b0;
    d9 = '0;
    lat = 1;
    chk({tag, "_busy_c1"}, {31'd0, busy9}, 32'd1);
    chk({tag, "_ready_lo"}, {31'd0, or9}, 32'd0);
    while (!ov9 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd5);
    chk({tag, "_data"}, od9, exp);
    chk({tag, "_ready_done"}, {31'd0, or9}, 32'd0);
    if (post && r9) begin
      @(negedge clk);
      chk({tag, "_valid_drop"}, {31'd0, ov9}, 32'd0);
      chk({tag, "_ready_back"}, {31'd0, or9}, 32'd1);
      chk({tag, "_busy_drop"}, {31'd0, busy9}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    d9 = '0; v9 = 1'b0; r9 = 1'b1;
    d1 = '0; v1 = 1'b0; r1 = 1'b1;
    d2 = '0; v2 = 1'b0; r2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, or9}, 32'd1);
    chk("rst_valid", {31'd0, ov9}, 32'd0);
    chk("rst_busy", {31'd0, busy9}, 32'd0);
    chk("rst_data", od9, 32'd0);
`ifdef ADDER_TREE_SEQ_SATURATE_EN
    chk("rst_sat", {31'd0, sat9}, 32'd0);
`endif
    rst_n = 1'b1;

    // Single-input instance: result one cycle after accept.
    @(negedge clk);
    chk("n1_ready", {31'd0, or1}, 32'd1);
    d1 = 32'hFFFFFF85;
    v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    chk("n1_valid_c1", {31'd0, ov1}, 32'd1);
    chk("n1_data", od1, 32'hFFFFFF85);
    chk("n1_busy", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    chk("n1_valid_drop", {31'd0, ov1}, 32'd0);
    chk("n1_ready_back", {31'd0, or1}, 32'd1);

    // Two-input instance: result two cycles after accept.
    @(negedge clk);
    d2 = {32'd8, 32'd7};
    v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    chk("n2_valid_c1", {31'd0, ov2}, 32'd0);
    chk("n2_busy_c1", {31'd0, busy2}, 32'd1);
    @(negedge clk);
    chk("n2_valid_c2", {31'd0, ov2}, 32'd1);
    chk("n2_data", od2, 32'd15);

    vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    xfer9(pack9(), 32'd45, "seq", 1'b1);

    vec = '{-5, 3, -7, 100, 0, -1, 2, -2, 10};
    xfer9(pack9(), 32'd100, "mix", 1'b0);
    vec = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
    xfer9(pack9(), 32'hFFFFFFF7, "neg", 1'b1);

    vec = '{32'h7FFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0};
`ifdef ADDER_TREE_SEQ_SATURATE_EN
    xfer9(pack9(), 32'h7FFFFFFF, "ovf", 1'b0);
    chk("ovf_sat", {31'd0, sat9}, 32'd1);
`else
    xfer9(pack9(), 32'h80000000, "ovf", 1'b0);
`endif
    vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    xfer9(pack9(), 32'd45, "after_ovf", 1'b0);
`ifdef ADDER_TREE_SEQ_SATURATE_EN
    chk("after_ovf_sat", {31'd0, sat9}, 32'd0);
`endif

    // Backpressure: output must hold while new vectors are offered and ignored.
    @(negedge clk);
    r9 = 1'b0;
    xfer9(pack9(), 32'd45, "bp", 1'b0);
    vec = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      d9 = pack9();
      v9 = 1'b1;
      chk("bp_hold_data", od9, 32'd45);
      chk("bp_hold_valid", {31'd0, ov9}, 32'd1);
      chk("bp_hold_ready", {31'd0, or9}, 32'd0);
    end
    @(negedge clk);
    chk("bp_last_data", od9, 32'd45);
    v9 = 1'b0;
    r9 = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", {31'd0, ov9}, 32'd0);
    chk("bp_ready_back", {31'd0, or9}, 32'd1);

    // Asynchronous reset during the second REDUCE cycle.
    vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    @(negedge clk);
    d9 = pack9();
    v9 = 1'b1;
    @(negedge clk);
    v9 = 1'b0;
    @(negedge clk);
    chk("ar_busy_before", {31'd0, busy9}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, ov9}, 32'd0);
    chk("ar_ready", {31'd0, or9}, 32'd1);
    chk("ar_busy", {31'd0, busy9}, 32'd0);
    chk("ar_data", od9, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xfer9(pack9(), 32'd45, "post_rst", 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
